time_set_ctrl: RTL and testbench
================================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 1_000_000, number of consecutive stable clk cycles a key must hold before its new level is accepted (20 ms at 50 MHz).
REQ-002 Parameter RPT_DELAY, default 50_000_000, clk cycles key_inc must stay pressed before auto-repeat starts.
REQ-003 Parameter RPT_PERIOD, default 10_000_000, clk cycles between auto-repeat increments.
REQ-004 clk  input  1  system clock, 50 MHz; all logic rising-edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 key_mode  input  1  raw mode button, asynchronous, active-low (pressed = 0).
REQ-007 key_inc  input  1  raw increment button, asynchronous, active-low.
REQ-008 time_in  input  24  current binary time from the clock counter; hour [23:16], minute [15:8], second [7:0].
REQ-009 time_out  output  24  edited binary time, same field layout as time_in.
REQ-010 load  output  1  one-cycle strobe; clock counter replaces its time with time_out.
REQ-011 editing  output  1  high in any SET state.
REQ-012 blink_sel  output  3  one-hot field under edit for the display blinker: [2] hour, [1] minute, [0] second; 000 in RUN.

Function
REQ-013 Each key passes through a 2-flop synchronizer, then a debouncer; debounced level changes only after DB_CYCLES consecutive equal synchronized samples.
REQ-014 A press event is a one-cycle pulse in the cycle the debounced level goes from released to pressed; releases generate no event.
REQ-015 FSM states: RUN, SET_HOUR, SET_MIN, SET_SEC.
REQ-016 RUN + mode event -> SET_HOUR; edit register loads time_in in the same edge.
REQ-017 Captured field out of range (hour > 23, minute or second > 59) loads as 0.
REQ-018 SET_HOUR + mode -> SET_MIN; SET_MIN + mode -> SET_SEC; SET_SEC + mode -> RUN with load = 1 for exactly the next cycle.
REQ-019 Inc event in a SET state increments the active field by 1; hour wraps 23 -> 0, minute and second wrap 59 -> 0; other fields are unchanged; no carry into the neighbouring field.
REQ-020 Inc events in RUN are ignored.
REQ-021 Auto-repeat: while debounced key_inc stays pressed in a SET state, the first extra increment occurs RPT_DELAY cycles after the press event, then one every RPT_PERIOD cycles; release or a state change stops it.
REQ-022 Mode and inc events in the same cycle: mode wins, inc is discarded.
REQ-023 time_out always equals the edit register; load is high only as in REQ-018.
REQ-024 editing and blink_sel are registered decodes of the state, valid the cycle after each transition.
REQ-025 In RUN, time_out holds the last committed or captured value; time_in changes do not affect it.

Reset
REQ-026 While rst = 1: state = RUN, time_out = 0, load = 0, editing = 0, blink_sel = 000, debouncers at released level with counters 0, repeat counters 0.
REQ-027 Reset during a SET state abandons the edit; no load is issued at or after reset.
REQ-028 After reset, a key already held low produces exactly one press event once stable for DB_CYCLES.

Structure
REQ-029 Shared package clock_pkg holds the state enum, the constants HOUR_MAX = 23 and MIN_SEC_MAX = 59, and the field bit positions of the 24-bit time bus.
REQ-030 Sub-module key_debounce (synchronizer, debounce counter, press pulse, DB_CYCLES parameter) is instantiated once per key.
REQ-031 No latches; every output is registered.

Verification (bench sets DB_CYCLES = 4, RPT_DELAY = 20, RPT_PERIOD = 5)
REQ-032 time_in = 0x0C_1E_2D (12:30:45); press mode 4x, no inc -> one load pulse with time_out = 0x0C1E2D; blink_sel sequence 100, 010, 001, 000.
REQ-033 Capture 23:59:59; in each SET state press inc once -> load with time_out = 0x000000.
REQ-034 Key_inc glitches low 3 cycles then high -> no increment; a 6-cycle low pulse -> exactly one increment.
REQ-035 SET_MIN from minute 10, hold key_inc 40 cycles after debounce -> minute = 15 (1 + 4 repeats at cycles 20, 25, 30, 35).
REQ-036 Mode and inc debounced in the same cycle in SET_HOUR -> moves to SET_MIN, hour unchanged.
REQ-037 rst pulsed in SET_SEC -> state RUN, time_out = 0, no load pulse in the next 100 cycles.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types, limits and time-bus field layout for the time-setting controller.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_SEC  = 2'd3
    } state_t;

    localparam logic [7:0] HOUR_MAX    = 8'd23;
    localparam logic [7:0] MIN_SEC_MAX = 8'd59;

    localparam int HOUR_MSB = 23;
    localparam int HOUR_LSB = 16;
    localparam int MIN_MSB  = 15;
    localparam int MIN_LSB  = 8;
    localparam int SEC_MSB  = 7;
    localparam int SEC_LSB  = 0;

    localparam logic [2:0] BLINK_NONE = 3'b000;
    localparam logic [2:0] BLINK_HOUR = 3'b100;
    localparam logic [2:0] BLINK_MIN  = 3'b010;
    localparam logic [2:0] BLINK_SEC  = 3'b001;

    // A field that cannot be a valid time reading is replaced by zero.
    function automatic logic [7:0] field_clamp(input logic [7:0] val, input logic [7:0] max_val);
        return (val > max_val) ? 8'd0 : val;
    endfunction

    // Increment with wrap at the field maximum; no carry leaves the field.
    function automatic logic [7:0] field_inc(input logic [7:0] val, input logic [7:0] max_val);
        return (val >= max_val) ? 8'd0 : (val + 8'd1);
    endfunction

    function automatic logic [2:0] blink_decode(input state_t st);
        logic [2:0] sel;
        case (st)
            ST_SET_HOUR: sel = BLINK_HOUR;
            ST_SET_MIN:  sel = BLINK_MIN;
            ST_SET_SEC:  sel = BLINK_SEC;
            default:     sel = BLINK_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Button conditioner: 2-flop synchronizer, stability debouncer and press pulse.
// Key input is active-low; outputs are active-high.
module key_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pressed,
    output logic press_evt
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    logic w_differ;
    logic w_accept;

    assign w_differ  = (r_sync2 != r_level);
    assign w_accept  = w_differ && (r_cnt == CNT_LAST);
    assign pressed   = ~r_level;
    assign press_evt = r_press;

    // Bring the asynchronous key into the clk domain; idle level is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive samples that disagree with the accepted level; flip on the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_press <= 1'b0;
        end else begin
            r_press <= w_accept && !r_sync2;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: mode key walks hour/minute/second editing, inc key
// bumps the active field (with auto-repeat), and the final mode press commits.
//
// state        | meaning
// -------------+------------------------------------------------
// ST_RUN       | not editing; time_out holds last captured/committed value
// ST_SET_HOUR  | hour field under edit
// ST_SET_MIN   | minute field under edit
// ST_SET_SEC   | second field under edit; next mode commits with load
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int DB_CYCLES  = 1_000_000,
    parameter int RPT_DELAY  = 50_000_000,
    parameter int RPT_PERIOD = 10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_mode,
    input  logic        key_inc,
    input  logic [23:0] time_in,
    output logic [23:0] time_out,
    output logic        load,
    output logic        editing,
    output logic [2:0]  blink_sel
);

    localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(RPT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(RPT_PERIOD - 1);

    state_t           r_state;
    logic [23:0]      r_edit;
    logic             r_load;
    logic             r_editing;
    logic [2:0]       r_blink;
    logic             r_rpt_active;
    logic [RPT_W-1:0] r_rpt_cnt;

    state_t      w_state_nxt;
    logic [23:0] w_edit_nxt;
    logic        w_load_nxt;
    logic        w_mode_pressed;
    logic        w_mode_evt;
    logic        w_inc_pressed;
    logic        w_inc_evt;
    logic        w_mode_go;
    logic        w_rpt_fire;
    logic        w_inc_go;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
        .clk       (clk),
        .rst       (rst),
        .key_n     (key_mode),
        .pressed   (w_mode_pressed),
        .press_evt (w_mode_evt)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
        .clk       (clk),
        .rst       (rst),
        .key_n     (key_inc),
        .pressed   (w_inc_pressed),
        .press_evt (w_inc_evt)
    );

    // A press pulse always coincides with the debounced level being low.
    assign w_mode_go  = w_mode_evt && w_mode_pressed;
    assign w_rpt_fire = r_rpt_active && w_inc_pressed && (r_state != ST_RUN) && (r_rpt_cnt == '0);
    // Mode has priority: inc is consumed only when no mode event is present.
    assign w_inc_go   = (w_inc_evt || w_rpt_fire) && !w_mode_go;

    assign time_out  = r_edit;
    assign load      = r_load;
    assign editing   = r_editing;
    assign blink_sel = r_blink;

    // State, edit register and registered output decodes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_edit    <= '0;
            r_load    <= 1'b0;
            r_editing <= 1'b0;
            r_blink   <= BLINK_NONE;
        end else begin
            r_state   <= w_state_nxt;
            r_edit    <= w_edit_nxt;
            r_load    <= w_load_nxt;
            r_editing <= (w_state_nxt != ST_RUN);
            r_blink   <= blink_decode(w_state_nxt);
        end
    end

    // Next-state, field edits and commit strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_edit_nxt  = r_edit;
        w_load_nxt  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_mode_go) begin
                    w_state_nxt = ST_SET_HOUR;
                    w_edit_nxt  = {field_clamp(time_in[HOUR_MSB:HOUR_LSB], HOUR_MAX),
                                   field_clamp(time_in[MIN_MSB:MIN_LSB], MIN_SEC_MAX),
                                   field_clamp(time_in[SEC_MSB:SEC_LSB], MIN_SEC_MAX)};
                end
            end
            ST_SET_HOUR: begin
                if (w_mode_go) begin
                    w_state_nxt = ST_SET_MIN;
                end else if (w_inc_go) begin
                    w_edit_nxt[HOUR_MSB:HOUR_LSB] = field_inc(r_edit[HOUR_MSB:HOUR_LSB], HOUR_MAX);
                end
            end
            ST_SET_MIN: begin
                if (w_mode_go) begin
                    w_state_nxt = ST_SET_SEC;
                end else if (w_inc_go) begin
                    w_edit_nxt[MIN_MSB:MIN_LSB] = field_inc(r_edit[MIN_MSB:MIN_LSB], MIN_SEC_MAX);
                end
            end
            ST_SET_SEC: begin
                if (w_mode_go) begin
                    w_state_nxt = ST_RUN;
                    w_load_nxt  = 1'b1;
                end else if (w_inc_go) begin
                    w_edit_nxt[SEC_MSB:SEC_LSB] = field_inc(r_edit[SEC_MSB:SEC_LSB], MIN_SEC_MAX);
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Auto-repeat timer: armed by an accepted inc press, first fire after the
    // delay, then periodic; any release, mode event or RUN state disarms it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rpt_active <= 1'b0;
            r_rpt_cnt    <= '0;
        end else if ((r_state == ST_RUN) || w_mode_go || !w_inc_pressed) begin
            r_rpt_active <= 1'b0;
            r_rpt_cnt    <= '0;
        end else if (w_inc_evt) begin
            r_rpt_active <= 1'b1;
            r_rpt_cnt    <= RPT_DELAY_LAST;
        end else if (r_rpt_active) begin
            if (r_rpt_cnt == '0) begin
                r_rpt_cnt <= RPT_PERIOD_LAST;
            end else begin
                r_rpt_cnt <= r_rpt_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl with short debounce/repeat parameters.
module tb_time_set_ctrl;

    typedef struct packed {
        logic [2:0] blink;
        logic       editing;
    } blink_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_mode = 1'b1;
    logic        key_inc = 1'b1;
    logic [23:0] time_in = 24'h0;
    logic [23:0] time_out;
    logic        load;
    logic        editing;
    logic [2:0]  blink_sel;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    blink_exp_t  q_blink[$];
    logic [23:0] q_load[$];
    logic [2:0]  prev_blink = 3'b000;

    time_set_ctrl #(
        .DB_CYCLES  (4),
        .RPT_DELAY  (20),
        .RPT_PERIOD (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_mode  (key_mode),
        .key_inc   (key_inc),
        .time_in   (time_in),
        .time_out  (time_out),
        .load      (load),
        .editing   (editing),
        .blink_sel (blink_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_blink(input logic [2:0] b);
        blink_exp_t e;
        e.blink   = b;
        e.editing = (b != 3'b000);
        q_blink.push_back(e);
    endtask

    // Hold the selected raw keys low for low_cyc samples, release, let it settle.
    task automatic press(input bit do_mode, input bit do_inc, input int low_cyc);
        @(negedge clk);
        if (do_mode) key_mode = 1'b0;
        if (do_inc)  key_inc  = 1'b0;
        tick(low_cyc);
        key_mode = 1'b1;
        key_inc  = 1'b1;
        tick(14);
    endtask

    task automatic tap_mode();
        press(1'b1, 1'b0, 8);
    endtask

    task automatic tap_inc(input int low_cyc);
        press(1'b0, 1'b1, low_cyc);
    endtask

    // Monitor: every load and every blink_sel change consumes one expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (load === 1'b1) begin
                if (q_load.size() == 0) begin
                    check("unexpected_load", 32'(load), 32'd0);
                end else begin
                    logic [23:0] exp_t;
                    exp_t = q_load.pop_front();
                    check("load_time_out", 32'(time_out), 32'(exp_t));
                end
            end
            if (blink_sel !== prev_blink) begin
                if (q_blink.size() == 0) begin
                    check("unexpected_blink", 32'(blink_sel), 32'(prev_blink));
                end else begin
                    blink_exp_t e;
                    e = q_blink.pop_front();
                    check("blink_sel", 32'(blink_sel), 32'(e.blink));
                    check("editing", 32'(editing), 32'(e.editing));
                end
                prev_blink = blink_sel;
            end
        end
    end

    initial begin
        tick(3);
        check("rst_time_out", 32'(time_out), 32'h0);
        check("rst_load", 32'(load), 32'h0);
        check("rst_editing", 32'(editing), 32'h0);
        check("rst_blink", 32'(blink_sel), 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;
        tick(2);

        // Plain walk through all SET states, commit unchanged time.
        time_in = 24'h0C1E2D;
        push_blink(3'b100); tap_mode();
        check("capture_12_30_45", 32'(time_out), 32'h0C1E2D);
        push_blink(3'b010); tap_mode();
        push_blink(3'b001); tap_mode();
        push_blink(3'b000); q_load.push_back(24'h0C1E2D); tap_mode();
        time_in = 24'h111111;
        tick(5);
        check("run_holds_value", 32'(time_out), 32'h0C1E2D);

        // Wrap of every field from its maximum.
        time_in = 24'h173B3B;
        push_blink(3'b100); tap_mode();
        check("capture_23_59_59", 32'(time_out), 32'h173B3B);
        tap_inc(8);
        check("hour_wrap", 32'(time_out), 32'h003B3B);
        push_blink(3'b010); tap_mode();
        tap_inc(8);
        check("min_wrap", 32'(time_out), 32'h00003B);
        push_blink(3'b001); tap_mode();
        tap_inc(8);
        check("sec_wrap", 32'(time_out), 32'h000000);
        push_blink(3'b000); q_load.push_back(24'h000000); tap_mode();

        // Out-of-range capture loads zeros.
        time_in = 24'h183C3C;
        push_blink(3'b100); tap_mode();
        check("capture_out_of_range", 32'(time_out), 32'h000000);
        push_blink(3'b010); tap_mode();
        push_blink(3'b001); tap_mode();
        push_blink(3'b000); q_load.push_back(24'h000000); tap_mode();

        // Inc in RUN is ignored.
        tap_inc(8);
        check("inc_in_run", 32'(time_out), 32'h000000);

        // Glitch rejection versus a valid short press.
        time_in = 24'h010203;
        push_blink(3'b100); tap_mode();
        tap_inc(3);
        check("glitch_3", 32'(time_out), 32'h010203);
        tap_inc(6);
        check("press_6", 32'(time_out), 32'h020203);
        push_blink(3'b010); tap_mode();
        push_blink(3'b001); tap_mode();
        push_blink(3'b000); q_load.push_back(24'h020203); tap_mode();

        // Auto-repeat on minute from 10.
        time_in = 24'h050A00;
        push_blink(3'b100); tap_mode();
        push_blink(3'b010); tap_mode();
        tap_inc(40);
        check("auto_repeat", 32'(time_out), 32'h050F00);
        push_blink(3'b001); tap_mode();
        push_blink(3'b000); q_load.push_back(24'h050F00); tap_mode();

        // Simultaneous mode and inc in SET_HOUR: mode wins.
        time_in = 24'h070809;
        push_blink(3'b100); tap_mode();
        push_blink(3'b010); press(1'b1, 1'b1, 8);
        check("mode_beats_inc", 32'(time_out), 32'h070809);
        push_blink(3'b001); tap_mode();

        // Reset abandons the edit with no commit.
        push_blink(3'b000);
        @(negedge clk);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check("rst_abandon_time_out", 32'(time_out), 32'h0);
        check("rst_abandon_editing", 32'(editing), 32'h0);
        tick(100);
        check("no_load_after_rst", 32'(time_out), 32'h0);

        // Key held through reset yields exactly one press.
        time_in = 24'h030405;
        push_blink(3'b100);
        @(negedge clk);
        key_mode = 1'b0;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(20);
        key_mode = 1'b1;
        tick(14);
        check("held_through_rst_capture", 32'(time_out), 32'h030405);

        tick(2);
        check("blink_queue_empty", 32'(q_blink.size()), 32'd0);
        check("load_queue_empty", 32'(q_load.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
